shift_pipe: RTL and testbench
=============================

Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter for the ALU datapath.
- Supersedes the single-mode combinational left shifter.
- Supports four shift modes: logical left, logical right, arithmetic right and rotate right.
- Produces an ARM-style carry-out and moves operands through a valid/ready handshake with full backpressure.
- Sits between operand fetch and the ALU result mux.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width; derived, never overridden.
- STAGES, 2, number of pipeline register stages, 1..SHW; the SHW shift levels are split as evenly as possible, with the earlier stages taking any extra levels.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept an operand this cycle
- in_data  in  WIDTH  value to shift
- in_amt  in  SHW  shift amount, 0..WIDTH-1
- in_mode  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- in_cin  in  1  carry flag passed through when in_amt = 0
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  shifted result
- out_cout  out  1  carry-out

Behaviour:
- Reset (rst_n low at a clock edge):
  - all stage valid bits clear, so out_valid = 0;
  - out_data = 0 and out_cout = 0;
  - all other pipeline data registers also go to 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards every in-flight operand; no result for those operands ever appears.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline advance:
  - advance = !out_valid || out_ready.
  - in_ready = advance. This is purely combinational; in_ready must not depend on in_valid.
  - When advance is high, every stage loads from its predecessor. Stage-0 valid loads in_valid && in_ready.
  - When advance is low, every stage holds, and out_data/out_cout stay stable while out_valid = 1.
- Latency and throughput:
  - With out_ready held high, a result appears exactly STAGES cycles after the input transfer.
  - Throughput is 1 result per cycle.
  - Results leave in input order; none are dropped or duplicated.
- Per level k (k = 0..SHW-1): if bit k of the amount is set, shift by 2^k.
  - Mode and amount travel with the data through every stage.
- Mode semantics for amount n, 1 <= n <= WIDTH-1:
  - LSL: out = in << n, zeros fill; cout = in[WIDTH-n].
  - LSR: out = in >> n, zeros fill; cout = in[n-1].
  - ASR: out = in >> n, in[WIDTH-1] fills; cout = in[n-1].
  - ROR: out = rotate right by n; cout = out[WIDTH-1].
- n = 0, any mode: out = in and cout = in_cin.
- Carry is tracked incrementally per level:
  - the last bit shifted out at each active level overwrites the running carry;
  - inactive levels pass the carry through.
- Simultaneous input and output transfer in the same cycle is legal and must not create a bubble.
- out_valid, once asserted, stays high until the output transfer; data must not change during that time.
- Amounts of WIDTH or more cannot be encoded; no clamping logic is required.

Test Plan:
- Reset then idle, WIDTH=32, STAGES=2:
  - hold rst_n low for 3 cycles, then release;
  - required: out_valid=0, out_data=0, out_cout=0 throughout, and in_ready=1 from the first cycle after release.
- Mode sweep, data 0x8000_0001, amt 1, out_ready=1:
  - LSL -> 0x0000_0002, cout 1;
  - LSR -> 0x4000_0000, cout 1;
  - ASR -> 0xC000_0000, cout 1;
  - ROR -> 0xC000_0000, cout 1;
  - each result arrives exactly 2 cycles after its input transfer.
- Boundary amounts:
  - LSL 0xFFFF_FFFF amt 31 -> 0x8000_0000, cout 1;
  - ASR 0x7FFF_FFFF amt 31 -> 0x0000_0000, cout 1;
  - any mode, amt 0, in_cin=1 -> data unchanged, cout 1.
- Backpressure:
  - stream 8 back-to-back LSL operands (data 0x1, amt 0..7);
  - hold out_ready low for 4 cycles mid-stream;
  - required: in_ready drops in the same cycle, out_data stays stable, results 0x1..0x80 arrive in order with none lost, and in_ready rises the same cycle out_ready returns.
- Reset mid-flight:
  - send 2 operands, then assert rst_n low for 1 cycle before either emerges;
  - required: neither result is ever presented, and out_valid=0 until new input.
- Parameter sweep:
  - WIDTH=8 with STAGES=1 and WIDTH=64 with STAGES=3;
  - random 10k operands checked against a reference model, with latency equal to STAGES and no bubbles under random out_ready.

Source files
------------

// File: rtl/shift_pipe.sv
// Pipelined four-mode barrel shifter (LSL/LSR/ASR/ROR) with ARM-style carry-out.
// The log2(WIDTH) shift levels are split across STAGES register stages and move through a valid/ready handshake.
module shift_pipe #(
   parameter int  WIDTH  = 32,
   parameter int  STAGES = 2,
   localparam int SHW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [1:0]       in_mode,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_cout
);

   localparam int BASE  = SHW / STAGES;
   localparam int EXTRA = SHW % STAGES;

   // First shift level handled by stage s; earlier stages absorb the remainder levels.
   function automatic int lvl_lo(input int s);
      return s * BASE + ((s < EXTRA) ? s : EXTRA);
   endfunction

   // One shift level of 2^k: returns {carry, shifted data}; carry is the last bit moved out.
   function automatic logic [WIDTH:0] shift_level(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] mode, input int k);
      int                      sh;
      logic                    c;
      logic [WIDTH-1:0]        r;
      logic [WIDTH-1:0]        lo_bits;
      logic [WIDTH-1:0]        hi_bits;
      logic signed [WIDTH-1:0] sd;
      sh      = 1 << k;
      sd      = $signed(d);
      lo_bits = d >> (sh - 1);
      hi_bits = d >> (WIDTH - sh);
      c       = lo_bits[0];
      case (mode)
         2'b00: begin
            r = d << sh;
            c = hi_bits[0];
         end
         2'b01:   r = d >> sh;
         2'b10:   r = $unsigned(sd >>> sh);
         default: r = (d >> sh) | (d << (WIDTH - sh));
      endcase
      return {c, r};
   endfunction

   logic advance;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int LO = lvl_lo(s);
      localparam int HI = lvl_lo(s + 1);

      logic [WIDTH-1:0] src_d;
      logic             src_c;
      logic [SHW-1:0]   src_a;
      logic [1:0]       src_m;
      logic             src_v;
      logic [WIDTH-1:0] data_n;
      logic             cy_n;
      logic [WIDTH-1:0] data_p;
      logic             cy_p;
      logic             vld_p;

      if (s == 0) begin : g_src
         assign src_d = in_data;
         assign src_c = in_cin;
         assign src_a = in_amt;
         assign src_m = in_mode;
         assign src_v = in_valid;
      end else begin : g_src
         assign src_d = g_stage[s-1].data_p;
         assign src_c = g_stage[s-1].cy_p;
         assign src_a = g_stage[s-1].g_fwd.amt_p;
         assign src_m = g_stage[s-1].g_fwd.mode_p;
         assign src_v = g_stage[s-1].vld_p;
      end

      always_comb begin
         logic [WIDTH:0] lv;
         logic [SHW-1:0] a_sh;
         data_n = src_d;
         cy_n   = src_c;
         lv     = '0;
         a_sh   = '0;
         for (int k = LO; k < HI; k++) begin
            a_sh = src_a >> k;
            if (a_sh[0]) begin
               lv     = shift_level(data_n, src_m, k);
               data_n = lv[WIDTH-1:0];
               cy_n   = lv[WIDTH];
            end
         end
      end

      // Stage s register boundary: everything holds together when the output is stalled.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            vld_p  <= 1'b0;
            data_p <= '0;
            cy_p   <= 1'b0;
         end else if (advance) begin
            vld_p  <= src_v;
            data_p <= data_n;
            cy_p   <= cy_n;
         end
      end

      if (s < STAGES - 1) begin : g_fwd
         logic [SHW-1:0] amt_p;
         logic [1:0]     mode_p;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               amt_p  <= '0;
               mode_p <= '0;
            end else if (advance) begin
               amt_p  <= src_a;
               mode_p <= src_m;
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].vld_p;
   assign out_data  = g_stage[STAGES-1].data_p;
   assign out_cout  = g_stage[STAGES-1].cy_p;
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: three parameter sets run side by side, each checked every cycle
// against a queue-based reference built from plain shift/rotate arithmetic.
module tb_shift_pipe;

   logic clk;
   int   total = 0;
   int   bad   = 0;
   bit   done [3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic logic bit_at(input logic [63:0] d, input int i);
      logic [63:0] t;
      t = d >> i;
      return t[0];
   endfunction

   // Reference result {cout, data} for a w-bit operand.
   function automatic logic [64:0] model(input logic [63:0] din, input int amt,
                                         input logic [1:0] mode, input logic cin, input int w);
      logic [63:0] mask, d, r;
      logic        c;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      d    = din & mask;
      if (amt == 0) return {cin, d};
      case (mode)
         2'd0: begin r = (d << amt) & mask; c = bit_at(d, w - amt); end
         2'd1: begin r = d >> amt; c = bit_at(d, amt - 1); end
         2'd2: begin
            r = d >> amt;
            if (bit_at(d, w - 1)) r = r | (mask & ~(mask >> amt));
            c = bit_at(d, amt - 1);
         end
         default: begin
            r = ((d >> amt) | (d << (w - amt))) & mask;
            c = bit_at(r, w - 1);
         end
      endcase
      return {c, r};
   endfunction

   initial begin
      check("pin_lsl", model(64'h8000_0001, 1, 2'd0, 1'b0, 32), {1'b1, 64'h0000_0002});
      check("pin_lsr", model(64'h8000_0001, 1, 2'd1, 1'b0, 32), {1'b1, 64'h4000_0000});
      check("pin_asr", model(64'h8000_0001, 1, 2'd2, 1'b0, 32), {1'b1, 64'hC000_0000});
      check("pin_ror", model(64'h8000_0001, 1, 2'd3, 1'b0, 32), {1'b1, 64'hC000_0000});
      check("pin_lsl31", model(64'hFFFF_FFFF, 31, 2'd0, 1'b0, 32), {1'b1, 64'h8000_0000});
      check("pin_asr31", model(64'h7FFF_FFFF, 31, 2'd2, 1'b0, 32), {1'b1, 64'h0});
      check("pin_amt0", model(64'h1234_5678, 0, 2'd3, 1'b1, 32), {1'b1, 64'h1234_5678});
      check("pin_ror8", model(64'h81, 4, 2'd3, 1'b0, 8), {1'b0, 64'h18});
      check("pin_asr8", model(64'h84, 3, 2'd2, 1'b0, 8), {1'b1, 64'hF0});
   end

   typedef struct {
      logic [63:0] d;
      logic        c;
      int          tx;
      int          st;
   } exp_t;

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int W    = (g == 0) ? 32 : (g == 1) ? 8 : 64;
      localparam int ST   = (g == 0) ? 2 : (g == 1) ? 1 : 3;
      localparam int SW   = $clog2(W);
      localparam int NOPS = (g == 0) ? 2000 : 5000;

      logic          rst_n;
      logic          in_valid;
      logic          in_ready;
      logic [W-1:0]  in_data;
      logic [SW-1:0] in_amt;
      logic [1:0]    in_mode;
      logic          in_cin;
      logic          out_valid;
      logic          out_ready;
      logic [W-1:0]  out_data;
      logic          out_cout;

      shift_pipe #(.WIDTH(W), .STAGES(ST)) dut (
         .clk(clk), .rst_n(rst_n),
         .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
         .in_amt(in_amt), .in_mode(in_mode), .in_cin(in_cin),
         .out_valid(out_valid), .out_ready(out_ready),
         .out_data(out_data), .out_cout(out_cout)
      );

      int   cyc      = 0;
      int   stall_at = -100;
      bit   rnd      = 1'b0;
      exp_t q[$];
      int   stalls    = 0;
      bit   prev_stall = 1'b0;
      bit   after_rst  = 1'b0;
      logic [W-1:0] prev_data;
      logic         prev_cout;

      always @(posedge clk) cyc <= cyc + 1;

      initial begin
         out_ready = 1'b1;
         forever begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            else out_ready = !(cyc >= stall_at && cyc < stall_at + 4);
         end
      end

      always @(negedge clk) begin
         exp_t e;
         int   due;
         if (after_rst) begin
            check($sformatf("w%0d_rst_valid", W), 64'(out_valid), 64'd0);
            check($sformatf("w%0d_rst_data", W), 64'(out_data), 64'd0);
            check($sformatf("w%0d_rst_cout", W), 64'(out_cout), 64'd0);
            check($sformatf("w%0d_rst_ready", W), 64'(in_ready), 64'd1);
         end
         if (!rst_n) begin
            q.delete();
            after_rst  = 1'b1;
            prev_stall = 1'b0;
         end else begin
            after_rst = 1'b0;
            check($sformatf("w%0d_in_ready", W), 64'(in_ready), 64'(!out_valid || out_ready));
            if (out_valid) begin
               if (q.size() == 0) begin
                  check($sformatf("w%0d_spurious", W), 64'(out_valid), 64'd0);
               end else begin
                  e   = q[0];
                  due = e.tx + ST + (stalls - e.st);
                  check($sformatf("w%0d_data", W), 64'(out_data), e.d);
                  check($sformatf("w%0d_cout", W), 64'(out_cout), 64'(e.c));
                  if (!prev_stall) check($sformatf("w%0d_latency", W), 64'(cyc), 64'(due));
               end
               if (prev_stall) begin
                  check($sformatf("w%0d_hold_data", W), 64'(out_data), 64'(prev_data));
                  check($sformatf("w%0d_hold_cout", W), 64'(out_cout), 64'(prev_cout));
               end
            end else begin
               if (prev_stall) check($sformatf("w%0d_hold_valid", W), 64'(out_valid), 64'd1);
               if (q.size() > 0) begin
                  due = q[0].tx + ST + (stalls - q[0].st);
                  check($sformatf("w%0d_overdue", W), 64'(cyc >= due), 64'd0);
               end
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
               logic [64:0] m;
               m    = model(64'(in_data), int'(in_amt), in_mode, in_cin, W);
               e.d  = m[63:0];
               e.c  = m[64];
               e.tx = cyc;
               e.st = stalls;
               q.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) stalls++;
            prev_data = out_data;
            prev_cout = out_cout;
         end
      end

      task automatic send(input logic [63:0] d, input int a, input logic [1:0] m, input logic c);
         int k;
         bit ok;
         k        = 0;
         ok       = 1'b0;
         in_data  = d[W-1:0];
         in_amt   = SW'(a);
         in_mode  = m;
         in_cin   = c;
         in_valid = 1'b1;
         while (!ok && k < 1000) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            k++;
         end
         if (!ok) check($sformatf("w%0d_send_timeout", W), 64'(ok), 64'd1);
         in_valid = 1'b0;
      endtask

      task automatic drain();
         int k;
         k = 0;
         while (q.size() != 0 && k < 1000) begin
            @(posedge clk);
            k++;
         end
         #1;
         check($sformatf("w%0d_drain", W), 64'(q.size()), 64'd0);
      endtask

      initial begin
         logic [63:0] msb1, ones;
         msb1     = (64'd1 << (W - 1)) | 64'd1;
         ones     = {64{1'b1}};
         rst_n    = 1'b0;
         in_valid = 1'b0;
         in_data  = '0;
         in_amt   = '0;
         in_mode  = 2'd0;
         in_cin   = 1'b0;
         repeat (3) @(posedge clk);
         #1 rst_n = 1'b1;
         repeat (3) begin @(posedge clk); #1; end

         for (int m = 0; m < 4; m++) send(msb1, 1, 2'(m), 1'b0);
         send(ones, W - 1, 2'd0, 1'b0);
         send(ones >> (65 - W), W - 1, 2'd2, 1'b0);
         for (int m = 0; m < 4; m++) send({$urandom(), $urandom()}, 0, 2'(m), 1'b1);
         drain();

         stall_at = cyc + 3;
         for (int a = 0; a < 8; a++) send(64'd1, a, 2'd0, 1'b0);
         drain();

         send(64'h5A, 1, 2'd1, 1'b0);
         in_data  = W'(8'h3C);
         in_amt   = SW'(2);
         in_valid = 1'b1;
         rst_n    = 1'b0;
         @(posedge clk);
         #1;
         rst_n    = 1'b1;
         in_valid = 1'b0;
         repeat (6) begin @(posedge clk); #1; end

         rnd = 1'b1;
         for (int i = 0; i < NOPS; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            send({$urandom(), $urandom()}, int'($urandom_range(0, W - 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         end
         rnd = 1'b0;
         drain();
         done[g] = 1'b1;
      end
   end

   initial begin
      int k;
      k = 0;
      while (!(done[0] && done[1] && done[2]) && k < 95000) begin
         @(posedge clk);
         k++;
      end
      check("all_done", 64'(done[0] && done[1] && done[2]), 64'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
